audio_clk_delay_bank: RTL and testbench

- Multi-channel programmable delay line for audio interface signals (BICK, LRCK, SDATA…), oversampled by clk_300m.
- Each channel is delayed by 0..MAX_DLY clk_300m cycles to deskew codec/ADC timing.
- Settings change through a valid/ready config handshake and are applied per channel only at glitch-free instants, with a timeout fallback.
- Sits between the external audio pins and the I2S/TDM receive logic.

---
 rtl/audio_clk_delay_bank.sv | 156 +++++++++++++++
 tb/tb_audio_clk_delay_bank.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_clk_delay_bank.sv
// Per-channel programmable delay line (0..MAX_DLY clk_300m cycles) with glitch-free config apply; optional SYNC_IN_EN input synchroniser.
// Latency: d cycles (d=0 combinational bypass), +2 with SYNC_IN_EN; config settles when taps match or after TIMEOUT cycles in APPLY.
// Backpressure: cfg_ready low outside IDLE; cfg_valid while not ready is dropped, never queued.
`timescale 1ns/1ps
module audio_clk_delay_bank #(
    parameter int NCH     = 3,
    parameter int MAX_DLY = 15,
    parameter int DW      = $clog2(MAX_DLY + 1),
    parameter int TIMEOUT = 1023
) (
    input  logic              clk_300m,
    input  logic              rst,
    input  logic [NCH-1:0]    sig_in,
    output logic [NCH-1:0]    sig_out,
    input  logic [NCH*DW-1:0] cfg_delay,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              cfg_done,
    output logic              cfg_forced,
    output logic [NCH*DW-1:0] act_delay
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    state_t           state;
    logic [NCH-1:0]   src;
    logic [MAX_DLY-1:0] sr [NCH];
    logic [DW-1:0]    act [NCH];
    logic [DW-1:0]    shd [NCH];
    logic [DW-1:0]    req [NCH];
    logic [NCH-1:0]   pending;
    logic [NCH-1:0]   pend_new;
    logic [NCH-1:0]   eq;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             tmo;

`ifdef SYNC_IN_EN
    logic [NCH-1:0] sync1, sync2;
    always_ff @(posedge clk_300m) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
        end
    end
    assign src = sync2;
`else
    assign src = sig_in;
`endif

    // sr[i][k-1] holds stage k; it runs in every state so any new tap already has history
    always_ff @(posedge clk_300m) begin
        for (int i = 0; i < NCH; i++) begin
            if (rst) begin
                sr[i] <= '0;
            end else begin
                sr[i][0] <= src[i];
                for (int k = 1; k < MAX_DLY; k++) sr[i][k] <= sr[i][k-1];
            end
        end
    end

    function automatic logic tap(input logic [MAX_DLY-1:0] s, input logic x, input logic [DW-1:0] d);
        logic t;
        t = x;
        for (int k = 1; k <= MAX_DLY; k++) begin
            if (d == DW'(k)) t = s[k-1];
        end
        return t;
    endfunction

    function automatic logic [DW-1:0] clampd(input logic [DW-1:0] v);
        return (v > DW'(MAX_DLY)) ? DW'(MAX_DLY) : v;
    endfunction

    always_comb begin
        sig_out   = '0;
        act_delay = '0;
        pend_new  = '0;
        eq        = '0;
        for (int i = 0; i < NCH; i++) begin
            req[i]               = clampd(cfg_delay[i*DW +: DW]);
            pend_new[i]          = (req[i] != act[i]);
            eq[i]                = (tap(sr[i], src[i], act[i]) == tap(sr[i], src[i], shd[i]));
            sig_out[i]           = tap(sr[i], src[i], act[i]);
            act_delay[i*DW +: DW] = act[i];
        end
    end

    // Timeout fires in the TIMEOUT-th cycle spent in APPLY
    assign cnt_nxt = cnt + CW'(1);
    assign tmo     = (cnt_nxt == CW'(TIMEOUT));

    always_ff @(posedge clk_300m) begin
        if (rst) begin
            state      <= IDLE;
            cfg_ready  <= 1'b1;
            cfg_done   <= 1'b0;
            cfg_forced <= 1'b0;
            pending    <= '0;
            cnt        <= '0;
            for (int i = 0; i < NCH; i++) begin
                act[i] <= '0;
                shd[i] <= '0;
            end
        end else begin
            cfg_done   <= 1'b0;
            cfg_forced <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        for (int i = 0; i < NCH; i++) shd[i] <= req[i];
                        pending   <= pend_new;
                        cnt       <= '0;
                        cfg_ready <= 1'b0;
                        if (pend_new == '0) begin
                            state    <= DONE;
                            cfg_done <= 1'b1;
                        end else begin
                            state <= APPLY;
                        end
                    end
                end
                APPLY: begin
                    cnt <= cnt_nxt;
                    for (int i = 0; i < NCH; i++) begin
                        if (pending[i] && (eq[i] || tmo)) begin
                            act[i]     <= shd[i];
                            pending[i] <= 1'b0;
                        end
                    end
                    if ((pending & ~eq) == '0) begin
                        state    <= DONE;
                        cfg_done <= 1'b1;
                    end else if (tmo) begin
                        state      <= DONE;
                        cfg_done   <= 1'b1;
                        cfg_forced <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_audio_clk_delay_bank.sv
// Directed table-driven bench for audio_clk_delay_bank (MAX_DLY=10, TIMEOUT=16).
`timescale 1ns/1ps
module tb_audio_clk_delay_bank;
    localparam int NCH     = 3;
    localparam int MAX_DLY = 10;
    localparam int DW      = $clog2(MAX_DLY + 1);
    localparam int TIMEOUT = 16;
`ifdef SYNC_IN_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic              clk_300m = 1'b0;
    logic              rst;
    logic [NCH-1:0]    sig_in;
    logic [NCH-1:0]    sig_out;
    logic [NCH*DW-1:0] cfg_delay;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              cfg_done;
    logic              cfg_forced;
    logic [NCH*DW-1:0] act_delay;

    audio_clk_delay_bank #(.NCH(NCH), .MAX_DLY(MAX_DLY), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk_300m  (clk_300m),
        .rst       (rst),
        .sig_in    (sig_in),
        .sig_out   (sig_out),
        .cfg_delay (cfg_delay),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .cfg_forced(cfg_forced),
        .act_delay (act_delay)
    );

    always #5 clk_300m = ~clk_300m;

    typedef struct {
        int per0;
        int r0, r1, r2;
        int a0, a1, a2;
        int forced;
        int apply;
        int track;
        int poke;
    } vec_t;

    vec_t tv [7];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int per [NCH];
    logic [NCH-1:0] hist [0:15];
    int done_cnt = 0;
    int trk = 0, first = 0, seen_edge = 0, run = 0, minrun = 1000;
    logic prev = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [NCH*DW-1:0] pack3(input int a, input int b, input int c);
        logic [NCH*DW-1:0] v;
        v = '0;
        v[0 +: DW]    = DW'(a);
        v[DW +: DW]   = DW'(b);
        v[2*DW +: DW] = DW'(c);
        return v;
    endfunction

    // One clock: drive new sig_in 1ns after the edge, settle, then observe
    task automatic step();
        logic [NCH-1:0] nv;
        @(posedge clk_300m);
        #1;
        cyc++;
        for (int i = 0; i < NCH; i++)
            nv[i] = (per[i] == 0) ? 1'b0 : 1'(((cyc / (per[i] / 2)) % 2));
        sig_in = nv;
        for (int j = 15; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = nv;
        #3;
        if (cfg_done) done_cnt++;
        if (trk != 0) begin
            if (first != 0) begin
                prev = sig_out[0]; run = 1; first = 0; seen_edge = 0;
            end else if (sig_out[0] == prev) begin
                run++;
            end else begin
                if (seen_edge != 0 && run < minrun) minrun = run;
                seen_edge = 1; run = 1; prev = sig_out[0];
            end
        end
    endtask

    task automatic out_window(input int n, input int d0, input int d1, input int d2, input string tag);
        int bad [NCH];
        int d [NCH];
        d[0] = d0; d[1] = d1; d[2] = d2;
        for (int i = 0; i < NCH; i++) bad[i] = 0;
        repeat (n) begin
            step();
            for (int i = 0; i < NCH; i++)
                if (sig_out[i] !== hist[d[i] + LAT][i]) bad[i]++;
        end
        for (int i = 0; i < NCH; i++) chk($sformatf("%s_out_ch%0d_bad_cycles", tag, i), bad[i], 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int apply, got_done, got_forced, rdy_hi;
        tv[0] = '{10,  3, 7, 0,  3, 7, 0, 0, -1, 0, 0};
        tv[1] = '{10, 15, 7, 0, 10, 7, 0, 0, -1, 0, 0};
        tv[2] = '{10, 15, 7, 0, 10, 7, 0, 0,  0, 0, 0};
        tv[3] = '{20,  2, 7, 0,  2, 7, 0, 0, -1, 0, 0};
        tv[4] = '{20,  9, 7, 0,  9, 7, 0, 0, -1, 1, 0};
        tv[5] = '{ 2,  1, 7, 0,  1, 7, 0, 0,  1, 0, 0};
        tv[6] = '{ 2,  2, 7, 0,  2, 7, 0, 1, 16, 0, 1};
        for (int j = 0; j < 16; j++) hist[j] = '0;
        for (int i = 0; i < NCH; i++) per[i] = 0;
        rst = 1'b1; cfg_valid = 1'b0; cfg_delay = '0; sig_in = '0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_act_delay", int'(act_delay), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_cfg_done", int'(cfg_done), 0);
        chk("rst_cfg_forced", int'(cfg_forced), 0);

        per[0] = 2; per[1] = 10; per[2] = 6;
        done_cnt = 0;
        out_window(12, 0, 0, 0, "bypass");

        for (int v = 0; v < 7; v++) begin
            if (per[0] != tv[v].per0) begin
                per[0] = tv[v].per0;
                repeat (25) step();
            end else begin
                repeat (3) step();
            end
            if (tv[v].track != 0) begin
                trk = 1; first = 1; minrun = 1000; seen_edge = 0;
            end
            cfg_delay = pack3(tv[v].r0, tv[v].r1, tv[v].r2);
            cfg_valid = 1'b1;
            chk($sformatf("v%0d_ready_idle", v), int'(cfg_ready), 1);
            step();
            cfg_valid = 1'b0;
            if (tv[v].poke != 0) begin
                cfg_valid = 1'b1;
                cfg_delay = pack3(4, 4, 4);
            end
            apply = 0; got_done = 0; got_forced = 0; rdy_hi = 0;
            for (int k = 0; k < 100; k++) begin
                if (cfg_done) begin
                    got_done = 1; got_forced = int'(cfg_forced);
                    break;
                end
                apply++;
                if (cfg_ready) rdy_hi++;
                step();
                cfg_valid = 1'b0;
            end
            chk($sformatf("v%0d_done_seen", v), got_done, 1);
            chk($sformatf("v%0d_forced", v), got_forced, tv[v].forced);
            if (tv[v].apply >= 0) chk($sformatf("v%0d_apply_cycles", v), apply, tv[v].apply);
            chk($sformatf("v%0d_ready_low_in_apply", v), rdy_hi, 0);
            step();
            chk($sformatf("v%0d_done_one_cycle", v), int'(cfg_done), 0);
            chk($sformatf("v%0d_act_ch0", v), int'(act_delay[0 +: DW]), tv[v].a0);
            chk($sformatf("v%0d_act_ch1", v), int'(act_delay[DW +: DW]), tv[v].a1);
            chk($sformatf("v%0d_act_ch2", v), int'(act_delay[2*DW +: DW]), tv[v].a2);
            done_cnt = 0;
            out_window(20, tv[v].a0, tv[v].a1, tv[v].a2, $sformatf("v%0d", v));
            chk($sformatf("v%0d_no_extra_done", v), done_cnt, 0);
            if (tv[v].track != 0) begin
                trk = 0;
                n_cmp++;
                if (minrun < 10) begin
                    n_bad++;
                    $display("FAIL v%0d_min_pulse_width: got %0d required >= 10", v, minrun);
                end
            end
        end

        // Reset in the middle of an APPLY that can never match (1 vs 2 on a per-cycle toggle)
        cfg_delay = pack3(1, 7, 0);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        done_cnt = 0;
        repeat (4) step();
        chk("midrst_in_apply", int'(cfg_ready), 0);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        chk("midrst_act_delay", int'(act_delay), 0);
        chk("midrst_cfg_ready", int'(cfg_ready), 1);
        out_window(20, 0, 0, 0, "midrst");
        chk("midrst_no_done", done_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
